imm_ins_encoder: RTL and testbench

- Inverse of the immediate generator: packs a sign-extended 64-bit immediate plus register and function fields into a 32-bit RV64 instruction word.
- Covers ld (I-type), sd (S-type) and branch (B-type) formats.
- Sits between the test/program loader and the instruction memory write port.
- Registered valid/ready stream; emits an incrementing byte write address with each word.

---
 rtl/imm_ins_encoder_pkg.sv | 19 +
 rtl/imm_ins_pack.sv | 30 +++
 rtl/imm_ins_encoder.sv | 109 ++++++++++
 tb/tb_imm_ins_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ins_encoder_pkg.sv
// Shared constants for the RV64 ld/sd/branch instruction encoder.
package imm_ins_encoder_pkg;

  localparam logic [1:0] LD_SEL = 2'b00;
  localparam logic [1:0] SD_SEL = 2'b01;
  localparam logic [1:0] BR_SEL = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  // True when a 64-bit value is the sign extension of its low 12 bits.
  function automatic logic fits_simm12(input logic [63:0] imm);
    return (&imm[63:11]) || !(|imm[63:11]);
  endfunction

endpackage

// File: rtl/imm_ins_pack.sv
// Combinational packer: format select, register fields and 12-bit immediate to a 32-bit word.
module imm_ins_pack
  import imm_ins_encoder_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  output logic [31:0] ins,
  output logic        illegal
);

  // Branch immediate is already the halved offset, so its bits map 1:1 into the B-type slots.
  always_comb begin
    ins     = NOP_INS;
    illegal = 1'b0;
    case (sel)
      LD_SEL:  ins = {imm, rs1, funct3, rd, OP_LOAD};
      SD_SEL:  ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      BR_SEL:  ins = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
      default: begin
        ins     = NOP_INS;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ins_encoder.sv
// Registered valid/ready instruction encoder with byte address and delivery counter.
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit signed 12 bits.
module imm_ins_encoder
  import imm_ins_encoder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       ins_count
);

  localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic [31:0]       pack_ins;
  logic              pack_illegal;
  logic              range_err;
  logic              accept;
  logic              deliver;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_ins_q,   out_ins_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic [15:0]       ins_count_q, ins_count_d;

  imm_ins_pack u_pack (
    .sel     (in_sel),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .imm     (in_imm[11:0]),
    .ins     (pack_ins),
    .illegal (pack_illegal)
  );

`ifdef IMM_RANGE_CHECK_EN
  assign range_err = !fits_simm12(in_imm);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[63:12];
  assign range_err     = 1'b0;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  // A new accept overwrites the word being delivered in the same cycle, keeping the stream bubble-free.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    ins_count_d = ins_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_ins_d   = pack_ins;
      out_err_d   = pack_illegal || range_err;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
    if (deliver) begin
      out_addr_d = out_addr_q + ADDR_STEP;
      if (ins_count_q != 16'hFFFF) begin
        ins_count_d = ins_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_addr_q  <= ADDR_RST;
      out_err_q   <= 1'b0;
      ins_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      ins_count_q <= ins_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign ins_count = ins_count_q;

endmodule

// File: tb/tb_imm_ins_encoder.sv
// Scoreboard bench for imm_ins_encoder: directed vectors queued at accept, checked by a monitor at delivery.
module tb_imm_ins_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RANGE_ERR = 1'b1;
`else
  localparam logic RANGE_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [7:0]  out_addr;
  logic        out_err;
  logic [15:0] ins_count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_ins;
  logic [3:0]  w_out_addr;
  logic        w_out_err;
  logic [15:0] w_ins_count;

  always #5 clk = ~clk;

  imm_ins_encoder #(.ADDR_W(8), .START_ADDR(0)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .ins_count (ins_count)
  );

  // Narrow-address instance with a nonzero start, so wrap-to-zero is distinguishable from wrap-to-start.
  imm_ins_encoder #(.ADDR_W(4), .START_ADDR(4)) u_wrap (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_sel    (in_sel),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .out_ins   (w_out_ins),
    .out_addr  (w_out_addr),
    .out_err   (w_out_err),
    .ins_count (w_ins_count)
  );

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  addr;
    logic        err;
    logic        legal;
    logic [63:0] rimm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_item;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_deliv  = 0;
  logic [7:0] exp_addr = 8'h00;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference decoder used for the round-trip check.
  function automatic logic [63:0] decode_imm(input logic [31:0] ins);
    logic [11:0] f;
    case (ins[6:5])
      2'b00:   f = ins[31:20];
      2'b01:   f = {ins[31:25], ins[11:7]};
      default: f = {ins[31], ins[7], ins[30:25], ins[11:8]};
    endcase
    return {{52{f[11]}}, f};
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_word: got %h, expected no word", out_ins);
      end else begin
        mon_item = sb_q.pop_front();
        checkOutput("ins", out_ins, mon_item.ins);
        checkOutput("addr", out_addr, mon_item.addr);
        checkOutput("err", out_err, mon_item.err);
        if (mon_item.legal) checkOutput("roundtrip", decode_imm(out_ins), mon_item.rimm);
      end
      n_deliv++;
    end
  end

  task automatic setFields(input logic [1:0] sel, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    in_sel    = sel;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has been accepted.
  task automatic applyStimulus(input logic [1:0] sel, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                               input logic [31:0] exp_ins, input logic exp_err);
    exp_t item;
    int   waited = 0;
    setFields(sel, rd, rs1, rs2, f3, imm);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("[TB] FAIL accept_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
    end else begin
      item.ins   = exp_ins;
      item.addr  = exp_addr;
      item.err   = exp_err;
      item.legal = (sel != 2'b10);
      item.rimm  = {{52{imm[11]}}, imm[11:0]};
      sb_q.push_back(item);
      exp_addr   = exp_addr + 8'd4;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL drain_timeout: %0d words pending, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] WRAP_ADDR [5] = '{4'h4, 4'h8, 4'hC, 4'h0, 4'h4};

  initial begin
    int n0;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    w_in_valid = 1'b0;
    out_ready  = 1'b1;
    setFields(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'h8);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_addr", out_addr, 8'h00);
    checkOutput("rst_ins_count", ins_count, 16'd0);
    checkOutput("rst_out_err", out_err, 1'b0);
    checkOutput("rst_out_ins", out_ins, 32'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'h8, 32'h00813283, 1'b0);
    applyStimulus(2'b00, 5'd1, 5'd0, 5'd0, 3'd3, 64'h800, 32'h80003083, RANGE_ERR);
    applyStimulus(2'b00, 5'd1, 5'd0, 5'd0, 3'd3, 64'hFFFF_FFFF_FFFF_F800, 32'h80003083, 1'b0);
    applyStimulus(2'b01, 5'd0, 5'd2, 5'd5, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFE513C23, 1'b0);
    applyStimulus(2'b11, 5'd0, 5'd1, 5'd3, 3'd1, 64'h7FF, 32'h7E309FE3, 1'b0);
    applyStimulus(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE000EE3, 1'b0);
    applyStimulus(2'b10, 5'd5, 5'd2, 5'd5, 3'd3, 64'h8, 32'h00000013, 1'b1);
    drain();
    checkOutput("count_after_7", ins_count, 16'd7);
    checkOutput("idle_valid", out_valid, 1'b0);

    // Backpressure: word A stalls with a second request waiting.
    out_ready = 1'b0;
    applyStimulus(2'b01, 5'd0, 5'd1, 5'd1, 3'd3, 64'h7FF, 32'h7E10BFA3, 1'b0);
    setFields(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'h8);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_ins", out_ins, 32'h7E10BFA3);
      checkOutput("bp_out_addr", out_addr, 8'h1C);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n0 = n_deliv;
    applyStimulus(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'h8, 32'h00813283, 1'b0);
    applyStimulus(2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 32'h00000013, 1'b1);
    applyStimulus(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE000EE3, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("no_bubble_delivers", 64'(n_deliv - n0), 64'd4);
    drain();
    checkOutput("count_after_11", ins_count, 16'd11);

    // Reset while a stalled word is held: it must be discarded.
    out_ready = 1'b0;
    applyStimulus(2'b00, 5'd7, 5'd7, 5'd0, 3'd3, 64'h10, 32'h01073383, 1'b0);
    reset_n = 1'b0;
    sb_q.delete();
    exp_addr = 8'h00;
    n_deliv  = 0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("midrst_out_addr", out_addr, 8'h00);
    checkOutput("midrst_ins_count", ins_count, 16'd0);
    out_ready = 1'b1;
    applyStimulus(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'h8, 32'h00813283, 1'b0);
    drain();
    checkOutput("count_after_rst", ins_count, 16'd1);

    // Address wrap on the 4-bit instance: 4,8,C,0,4.
    setFields(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 64'h1);
    w_in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("wrap_valid", w_out_valid, 1'b1);
      checkOutput("wrap_addr", w_out_addr, WRAP_ADDR[i]);
      if (i == 4) w_in_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("wrap_count", w_ins_count, 16'd5);
    checkOutput("wrap_idle", w_out_valid, 1'b0);

    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
